move_sequencer: RTL

- Controller between the four raw push-buttons and the character position datapath.
- Synchronizes and debounces KEY3..KEY0, generates press and auto-repeat events, and latches them as per-direction pending requests.
- Round-robin arbitrates the pending requests and issues at most one single-step move command per video frame over a valid/ready handshake to the position register block.

---
 rtl/move_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// Push-button front end for the character mover: sync, debounce, press/auto-repeat
// events, pending request latch, and a once-per-frame round-robin move issuer.
module move_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CW              = 25
) (
  input  logic       CLOCK50,
  input  logic       reset,
  input  logic       KEY3,
  input  logic       KEY2,
  input  logic       KEY1,
  input  logic       KEY0,
  input  logic       frame_tick,
  input  logic       mv_ready,
  output logic       mv_valid,
  output logic [1:0] mv_dir,
  output logic [3:0] pending,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  // Handshake: a move transfers on any cycle with mv_valid & mv_ready; while
  // mv_valid is high and mv_ready is low, mv_valid and mv_dir stay unchanged.
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_ISSUE      = 2'd2
  } state_t;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [CW-1:0] r_dcnt [4];
  logic [CW-1:0] r_hcnt [4];
  logic [3:0]    r_rep;
  logic [3:0]    r_pending;
  logic [1:0]    r_last_grant;
  logic          r_mv_valid;
  logic [1:0]    r_mv_dir;

  logic [3:0]    w_key_raw;
  logic [3:0]    w_db_diff;
  logic [3:0]    w_db_done;
  logic [3:0]    w_press;
  logic [3:0]    w_rep_hit;
  logic [3:0]    w_event;
  logic [3:0]    w_cancel;
  logic [3:0]    w_cand;
  logic          w_found;
  logic [1:0]    w_grant;
  logic [1:0]    w_idx;
  logic [3:0]    w_grant_oh;
  logic [3:0]    w_clr;

  // Bit d of every per-key vector corresponds to move direction d.
  assign w_key_raw = {KEY0, KEY1, KEY2, KEY3};

  always_comb begin
    w_db_diff = r_sync2 ^ r_deb;
    w_db_done = '0;
    w_rep_hit = '0;
    for (int d = 0; d < 4; d++) begin
      w_db_done[d] = w_db_diff[d] && (r_dcnt[d] == DB_LAST);
      w_rep_hit[d] = !r_deb[d] && (r_hcnt[d] == (r_rep[d] ? RP_LAST : RD_LAST));
    end
    w_press = w_db_done & ~r_sync2;
    w_event = w_press | w_rep_hit;
  end

  // Opposite pairs cancel before arbitration; search starts after the last grant.
  always_comb begin
    w_cancel = {{2{r_pending[3] & r_pending[2]}}, {2{r_pending[1] & r_pending[0]}}};
    w_cand   = r_pending & ~w_cancel;
    w_found  = 1'b0;
    w_grant  = 2'd0;
    w_idx    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last_grant + 2'(i);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
    w_grant_oh = w_found ? (4'b0001 << w_grant) : 4'b0000;
    w_clr      = (r_state == S_WAIT_FRAME && frame_tick) ? (w_cancel | w_grant_oh) : 4'b0000;
  end

  always_ff @(posedge CLOCK50) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sync1      <= 4'hF;
      r_sync2      <= 4'hF;
      r_deb        <= 4'hF;
      r_rep        <= 4'h0;
      r_pending    <= 4'h0;
      r_last_grant <= 2'd3;
      r_mv_valid   <= 1'b0;
      r_mv_dir     <= 2'd0;
      for (int d = 0; d < 4; d++) begin
        r_dcnt[d] <= '0;
        r_hcnt[d] <= '0;
      end
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      r_deb   <= r_deb ^ w_db_done;

      for (int d = 0; d < 4; d++) begin
        if (!w_db_diff[d] || w_db_done[d]) begin
          r_dcnt[d] <= '0;
        end else begin
          r_dcnt[d] <= r_dcnt[d] + CW'(1);
        end

        if (r_deb[d]) begin
          r_hcnt[d] <= '0;
          r_rep[d]  <= 1'b0;
        end else if (w_rep_hit[d]) begin
          r_hcnt[d] <= '0;
          r_rep[d]  <= 1'b1;
        end else begin
          r_hcnt[d] <= r_hcnt[d] + CW'(1);
        end
      end

      // A new event always wins over a same-cycle arbiter clear.
      r_pending <= (r_pending & ~w_clr) | w_event;

      case (r_state)
        S_IDLE: begin
          if (r_pending != 4'h0) begin
            r_state <= S_WAIT_FRAME;
          end
        end
        S_WAIT_FRAME: begin
          if (frame_tick) begin
            if (w_found) begin
              r_mv_valid   <= 1'b1;
              r_mv_dir     <= w_grant;
              r_last_grant <= w_grant;
              r_state      <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_ISSUE: begin
          if (r_mv_valid && mv_ready) begin
            r_mv_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mv_valid    = r_mv_valid;
  assign mv_dir      = r_mv_dir;
  assign pending     = r_pending;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
